branch_pred_unit: RTL

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/branch_pred_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_pred_unit.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Zero-latency fetch lookup, EX-stage resolve/update, mispredict stats.
`timescale 1ns/1ps
module branch_pred_unit #(
  parameter int ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_F,
  output logic        o_prediction,
  output logic [31:0] o_pc_target_F,
  input  logic        i_br_valid_E,
  input  logic        i_is_jump_E,
  input  logic        i_taken_E,
  input  logic [31:0] i_pc_E,
  input  logic [31:0] i_target_E,
  input  logic        i_pred_E,
  input  logic [31:0] i_pred_target_E,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_D,
  output logic        o_flush_E,
  output logic [15:0] o_mispred_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [15:0]        cnt_q;
  logic [15:0]        cnt_d;

  logic [IW-1:0] idx_f;
  logic [IW-1:0] idx_e;
  logic [TW-1:0] tag_f;
  logic [TW-1:0] tag_e;
  logic          hit_f;
  logic          hit_e;

  assign idx_f = i_pc_F[2+IW-1:2];
  assign tag_f = i_pc_F[31:2+IW];
  assign idx_e = i_pc_E[2+IW-1:2];
  assign tag_e = i_pc_E[31:2+IW];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign o_prediction =
    hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
  assign o_pc_target_F =
    hit_f ? tgt_q[idx_f] : i_pc_F + 32'd4;

  logic tgt_bad;
  assign tgt_bad = i_taken_E &&
    (i_target_E != i_pred_target_E);

  assign o_mispredict = i_br_valid_E && !i_rst &&
    ((i_taken_E != i_pred_E) || tgt_bad);
  assign o_redirect_pc =
    i_taken_E ? i_target_E : i_pc_E + 32'd4;
  assign o_flush_D = o_mispredict;
  assign o_flush_E = o_mispredict;

  logic        upd_en;
  logic [31:0] tgt_d;
  logic [1:0]  ctr_d;
  logic [1:0]  ctr_cur;

  assign ctr_cur = ctr_q[idx_e];

  always_comb begin
    upd_en = 1'b0;
    tgt_d  = tgt_q[idx_e];
    ctr_d  = ctr_cur;
    if (i_br_valid_E && !i_rst) begin
      if (hit_e) begin
        upd_en = 1'b1;
        if (i_taken_E) begin
          tgt_d = i_target_E;
        end
        if (i_is_jump_E) begin
          ctr_d = 2'b11;
        end else if (i_taken_E) begin
          ctr_d = (ctr_cur == 2'b11) ? 2'b11
                                     : ctr_cur + 2'd1;
        end else begin
          ctr_d = (ctr_cur == 2'b00) ? 2'b00
                                     : ctr_cur - 2'd1;
        end
      end else if (i_taken_E) begin
        // cold or aliased taken branch claims the slot
        upd_en = 1'b1;
        tgt_d  = i_target_E;
        ctr_d  = i_is_jump_E ? 2'b11 : 2'b10;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (o_mispredict && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign o_mispred_cnt = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      jump_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      cnt_q <= cnt_d;
      if (upd_en) begin
        valid_q[idx_e] <= 1'b1;
        jump_q[idx_e]  <= i_is_jump_E;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= tgt_d;
        ctr_q[idx_e]   <= ctr_d;
      end
    end
  end

endmodule
